inv_substitution_seq: RTL
=========================

// Module: inv_substitution_seq
// PURPOSE
//  Inverse SubBytes (InvS-box) stage for the AES-128 decryption datapath; the counterpart of
//  the forward Substitution stage. Accepts one 128-bit state via valid/ready, maps every byte
//  through the FIPS-197 inverse S-box over several cycles (LANES bytes/cycle), then presents
//  the result via valid/ready. Sits between InvShiftRows and AddRoundKey in the decrypt round.
// PARAMETERS
//  LANES  default 4  bytes substituted per cycle; legal values 1,2,4,8,16 (must divide 16)
// PORTS
//  CLK        in   1    clock; all state changes on rising edge
//  RST        in   1    synchronous, active-high reset
//  in_valid   in   1    Data_in holds a state to transform
//  in_ready   out  1    block can accept a state this cycle
//  Data_in    in   128  input state; byte 0 = [127:120] ... byte 15 = [7:0]
//  out_valid  out  1    Data_out holds a finished state
//  out_ready  in   1    downstream accepts Data_out this cycle
//  Data_out   out  128  InvSubBytes(Data_in), same byte order
//  busy       out  1    high in RUN or DONE
// BEHAVIOUR
//  - Interface: one CLK; RST synchronous active-high, sampled on the CLK rising edge.
//  - Reset: state=IDLE, internal state reg=0, group counter=0; in_ready=1, out_valid=0,
//    busy=0, Data_out=128'h0.
//  - FSM, 3 states:
//    IDLE: in_ready=1. in_valid&in_ready at an edge -> capture Data_in, counter=0, go RUN.
//    RUN:  each edge replaces bytes [counter*LANES .. counter*LANES+LANES-1] of the reg with
//          InvS(byte), counter++. At the edge processing the last group (counter=16/LANES-1)
//          -> DONE, counter=0.
//    DONE: out_valid=1, Data_out=reg (stable while out_valid). out_valid&out_ready at an
//          edge -> IDLE.
//  - Latency: out_valid is high 16/LANES cycles after the acceptance edge (LANES=4: 4 cycles;
//    LANES=16: 1 cycle). No overlap: one state in flight; in_ready=0 in RUN and DONE.
//  - Throughput: one state per 16/LANES+2 cycles when out_ready is held high.
//  - Backpressure: DONE holds indefinitely with Data_out unchanged until out_ready=1.
//  - in_valid during RUN/DONE is ignored (not captured, no error). Data_in changes after
//    acceptance do not affect the result.
//  - Data_out holds the last result after return to IDLE. It is only valid while
//    out_valid=1.
//  - RST mid-RUN or in DONE: the block discards the state in flight and re-enters the reset
//    values next cycle. RST has priority over every handshake in the same cycle.
//  - Counter width: $clog2(16/LANES), minimum 1 bit. It wraps to 0 only via the DONE
//    transition.
//  - Bytes are transformed independently. The order of substitution is not observable at the
//    ports.
// STRUCTURE
//  - Shared package aes_pkg: 256x8 INV_SBOX constant table, AES_BLOCK_BITS=128,
//    AES_BYTES=16, FSM state encoding (IDLE/RUN/DONE). The forward S-box table sits
//    alongside it.
//  - One sub-module inv_sbox (8-bit in -> 8-bit out, combinational lookup of INV_SBOX),
//    instantiated LANES times in a generate loop. Its inputs are muxed from the current group.
//  - Elaboration check: error if 16 % LANES != 0.
// TESTING
//  1. Reset: RST=1 for 2 cycles -> in_ready=1, out_valid=0, busy=0, Data_out=0.
//  2. Data_in=128'h0 accepted -> after 4 cycles (LANES=4) Data_out=16 bytes of 8'h52,
//     out_valid=1.
//  3. Data_in={16{8'h82}} -> {16{8'h11}}; then {16{8'h93}} -> {16{8'h22}}. This round-trips
//     the forward stage's 11../22.. results.
//  4. Data_in=128'h637C_FF63_..._637C (mixed) -> per byte 63->00, 7C->01, FF->7D.
//     Also check that byte ordering is preserved.
//  5. Backpressure: hold out_ready=0 for 10 cycles -> out_valid and Data_out stable,
//     in_ready=0, and a new in_valid is ignored. Release -> IDLE the next cycle.
//  6. Assert RST two cycles into RUN -> the next cycle shows the reset values. A following
//     block then completes correctly with no residue. Repeat steps 2-4 with LANES=1 and
//     LANES=16: latency 16 and 1.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES constants: forward S-box, inverse S-box derived from it, block sizes and
// the FSM encoding used by the sequential substitution stages.
package aes_pkg;

    localparam int AES_BLOCK_BITS = 128;
    localparam int AES_BYTES      = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Element 0 sits at the MSB end, so row-wise hex literals read like the FIPS-197 table.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Inverting the forward table keeps the two directions consistent by construction.
    function automatic logic [0:255][7:0] f_invert(input logic [0:255][7:0] fwd);
        logic [0:255][7:0] t;
        t = '0;
        for (int i = 0; i < 256; i++) begin
            t[fwd[i]] = 8'(i);
        end
        return t;
    endfunction

    localparam logic [0:255][7:0] INV_SBOX = f_invert(SBOX);

endpackage

// File: rtl/inv_sbox.sv
// Single-byte inverse S-box lookup, purely combinational.
module inv_sbox
    import aes_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    assign o_byte = INV_SBOX[i_byte];

endmodule

// File: rtl/inv_substitution_seq.sv
// Sequential InvSubBytes stage: substitutes LANES bytes per cycle of one captured state,
// then holds the result behind a valid/ready output handshake.
module inv_substitution_seq
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [AES_BLOCK_BITS-1:0] Data_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [AES_BLOCK_BITS-1:0] Data_out,
    output logic                      busy
);

    localparam int GROUPS = AES_BYTES / LANES;
    localparam int CW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;

    if (AES_BYTES % LANES != 0) begin : g_bad_lanes
        $error("inv_substitution_seq: LANES must divide 16");
    end

    state_t                     r_state, w_next_state;
    logic [CW-1:0]              r_cnt;
    logic [0:AES_BYTES-1][7:0]  r_data;
    logic [0:AES_BYTES-1][7:0]  r_out;
    logic [0:AES_BYTES-1][7:0]  w_data_sub;
    logic [LANES-1:0][7:0]      w_lane_in;
    logic [LANES-1:0][7:0]      w_lane_out;
    logic [LANES-1:0][3:0]      w_idx;
    logic                       w_last;

    assign w_last = (r_cnt == CW'(GROUPS - 1));

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign w_idx[l]     = 4'(32'(r_cnt) * LANES + l);
        assign w_lane_in[l] = r_data[w_idx[l]];
        inv_sbox u_sbox (
            .i_byte (w_lane_in[l]),
            .o_byte (w_lane_out[l])
        );
    end

    always_comb begin
        w_data_sub = r_data;
        for (int l = 0; l < LANES; l++) begin
            w_data_sub[w_idx[l]] = w_lane_out[l];
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)  w_next_state = ST_RUN;
            ST_RUN:  if (w_last)    w_next_state = ST_DONE;
            ST_DONE: if (out_ready) w_next_state = ST_IDLE;
            default:                w_next_state = ST_IDLE;
        endcase
    end

    // r_out is loaded only on completion, so Data_out never shows a partly substituted state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_data  <= '0;
            r_out   <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_data <= Data_in;
                        r_cnt  <= '0;
                    end
                end
                ST_RUN: begin
                    r_data <= w_data_sub;
                    if (w_last) begin
                        r_cnt <= '0;
                        r_out <= w_data_sub;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);
    assign Data_out  = r_out;

endmodule
